// File: rtl/osc_ro_pkg.sv
// osc_ro_pkg: shared FSM encoding, mode constants and helpers for the oscillator readout sequencer.
package osc_ro_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic MODE_SINGLE = 1'b0;
  localparam logic MODE_CONT = 1'b1;
  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/osc_slot_timer.sv
// osc_slot_timer: per-channel count window with registered counter-reset and sample strobes.
module osc_slot_timer #(
  parameter int WIN_W = 27,
  parameter int SAMPLE_AT = 7
) (
  input  logic clk,
  input  logic rstn,
  input  logic run,
  input  logic clear,
  output logic last,
  output logic resetn,
  output logic sample
);
  logic [WIN_W-1:0] cnt;
  assign last = &cnt;
  // Resetn drops for the first cycle of every window, including the very first one after start.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
      resetn <= 1'b0;
      sample <= 1'b0;
    end else begin
      cnt <= (run && !clear) ? cnt + 1'b1 : '0;
      resetn <= run && !clear && !last;
      sample <= run && !clear && cnt == WIN_W'(SAMPLE_AT);
    end
  end
endmodule

// File: rtl/osc_readout_sequencer.sv
// osc_readout_sequencer: steps the ring-oscillator select through its channels, one window each.
// Define OSC_MASK_EN to add osc_mask_i and skip disabled channels.
module osc_readout_sequencer
  import osc_ro_pkg::*;
#(
  parameter int NUM_OSC = 10,
  parameter int SEL_W = 5,
  parameter int WIN_W = 27,
  parameter int SAMPLE_AT = 7,
  parameter int SWEEP_W = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic               mode_i,
`ifdef OSC_MASK_EN
  input  logic [NUM_OSC-1:0] osc_mask_i,
`endif
  output logic [SEL_W-1:0]   OscSel_o,
  output logic               Resetn_o,
  output logic               Sample_o,
  output logic [SEL_W-1:0]   SampleSel_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [SWEEP_W-1:0] SweepCnt_o
);
  logic [NUM_OSC-1:0] mask;
`ifdef OSC_MASK_EN
  assign mask = osc_mask_i;
`else
  assign mask = '1;
`endif
  state_t state;
  logic mode, dead, last, run, sweep_end, halt, has_first, has_nxt;
  logic [SEL_W-1:0] first, nxt;
  always_comb begin
    first = '0;
    has_first = 1'b0;
    nxt = '0;
    has_nxt = 1'b0;
    for (int i = NUM_OSC - 1; i >= 0; i--) begin
      if (mask[i]) begin
        first = SEL_W'(i);
        has_first = 1'b1;
      end
      if (mask[i] && SEL_W'(i) > OscSel_o) begin
        nxt = SEL_W'(i);
        has_nxt = 1'b1;
      end
    end
  end
  assign run = state == RUN;
  // dead marks a run started with no enabled channel; it ends after one busy cycle.
  assign sweep_end = run && !stop_i && !dead && last && !has_nxt;
  assign halt = run && !stop_i && (dead || (sweep_end && (mode != MODE_CONT || !has_first)));
  osc_slot_timer #(.WIN_W(WIN_W), .SAMPLE_AT(SAMPLE_AT)) timer (
    .clk(clk),
    .rstn(rstn),
    .run(run),
    .clear(stop_i || halt),
    .last(last),
    .resetn(Resetn_o),
    .sample(Sample_o)
  );
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      mode <= MODE_SINGLE;
      dead <= 1'b0;
      OscSel_o <= '0;
      SampleSel_o <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      SweepCnt_o <= '0;
    end else begin
      done_o <= 1'b0;
      SampleSel_o <= OscSel_o;
      if (!run) begin
        if (start_i && !stop_i) begin
          state <= RUN;
          busy_o <= 1'b1;
          mode <= mode_i;
          dead <= !has_first;
          OscSel_o <= first;
          SweepCnt_o <= '0;
        end
      end else if (stop_i) begin
        state <= IDLE;
        busy_o <= 1'b0;
      end else begin
        if (sweep_end) SweepCnt_o <= SweepCnt_o + 1'b1;
        if (halt) begin
          state <= IDLE;
          busy_o <= 1'b0;
          done_o <= mode == MODE_SINGLE;
        end else if (last) OscSel_o <= has_nxt ? nxt : first;
      end
    end
  end
endmodule

// File: tb/tb_osc_readout_sequencer.sv
// tb_osc_readout_sequencer: directed table-driven bench for the readout sequencer (3 channels, 16-cycle windows).
module tb_osc_readout_sequencer;
  localparam int N = 3, SW = 5, WW = 4, SA = 7, CW = 16;
  logic clk = 1'b0, rstn = 1'b0, start_i = 1'b0, stop_i = 1'b0, mode_i = 1'b0;
  logic [SW-1:0] OscSel_o, SampleSel_o;
  logic Resetn_o, Sample_o, busy_o, done_o;
  logic [CW-1:0] SweepCnt_o;
`ifdef OSC_MASK_EN
  logic [N-1:0] osc_mask_i = '1;
`endif
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  osc_readout_sequencer #(.NUM_OSC(N), .SEL_W(SW), .WIN_W(WW), .SAMPLE_AT(SA), .SWEEP_W(CW)) dut (
    .clk(clk),
    .rstn(rstn),
    .start_i(start_i),
    .stop_i(stop_i),
    .mode_i(mode_i),
`ifdef OSC_MASK_EN
    .osc_mask_i(osc_mask_i),
`endif
    .OscSel_o(OscSel_o),
    .Resetn_o(Resetn_o),
    .Sample_o(Sample_o),
    .SampleSel_o(SampleSel_o),
    .busy_o(busy_o),
    .done_o(done_o),
    .SweepCnt_o(SweepCnt_o)
  );
  typedef struct {
    int cyc;
    logic [SW-1:0] sel;
    logic rn;
    logic smp;
    logic [SW-1:0] ssel;
    logic busy;
    logic done;
    logic [CW-1:0] sc;
  } vec_t;
  function automatic vec_t mk(int c, int sel, int rn, int smp, int ssel, int bsy, int dn, int sc);
    vec_t r;
    r.cyc = c;
    r.sel = SW'(sel);
    r.rn = rn[0];
    r.smp = smp[0];
    r.ssel = SW'(ssel);
    r.busy = bsy[0];
    r.done = dn[0];
    r.sc = CW'(sc);
    return r;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // Leaves the bench at the negedge where the first window cycle (cnt=0) is visible.
  task automatic start_run(input logic m);
    @(negedge clk);
    start_i = 1'b1;
    mode_i = m;
    @(negedge clk);
    start_i = 1'b0;
    mode_i = 1'b0;
  endtask
  function automatic logic [31:0] outs();
    return 32'({OscSel_o, Resetn_o, Sample_o, SampleSel_o, busy_o, done_o, SweepCnt_o});
  endfunction
  initial begin
    vec_t v[$];
    int j, dones, hits;
    repeat (2) @(negedge clk);
    chk("reset_outs", outs(), 0);
    rstn = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k % 5 == 4) chk("idle_outs", outs(), 0);
    end
    v.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0));
    v.push_back(mk(1, 0, 1, 0, 0, 1, 0, 0));
    v.push_back(mk(8, 0, 1, 1, 0, 1, 0, 0));
    v.push_back(mk(9, 0, 1, 0, 0, 1, 0, 0));
    v.push_back(mk(15, 0, 1, 0, 0, 1, 0, 0));
    v.push_back(mk(16, 1, 0, 0, 0, 1, 0, 0));
    v.push_back(mk(17, 1, 1, 0, 1, 1, 0, 0));
    v.push_back(mk(24, 1, 1, 1, 1, 1, 0, 0));
    v.push_back(mk(32, 2, 0, 0, 1, 1, 0, 0));
    v.push_back(mk(40, 2, 1, 1, 2, 1, 0, 0));
    v.push_back(mk(47, 2, 1, 0, 2, 1, 0, 0));
    v.push_back(mk(48, 2, 0, 0, 2, 0, 1, 1));
    v.push_back(mk(49, 2, 0, 0, 2, 0, 0, 1));
    start_run(1'b0);
    j = 0;
    for (int k = 0; k <= 49; k++) begin
      if (k > 0) @(negedge clk);
      if (j < v.size() && v[j].cyc == k) begin
        chk($sformatf("single_c%0d_sel", k), 32'(OscSel_o), 32'(v[j].sel));
        chk($sformatf("single_c%0d_resetn", k), 32'(Resetn_o), 32'(v[j].rn));
        chk($sformatf("single_c%0d_sample", k), 32'(Sample_o), 32'(v[j].smp));
        chk($sformatf("single_c%0d_samplesel", k), 32'(SampleSel_o), 32'(v[j].ssel));
        chk($sformatf("single_c%0d_busy", k), 32'(busy_o), 32'(v[j].busy));
        chk($sformatf("single_c%0d_done", k), 32'(done_o), 32'(v[j].done));
        chk($sformatf("single_c%0d_sweep", k), 32'(SweepCnt_o), 32'(v[j].sc));
        j++;
      end
      start_i = (k == 47);
      mode_i = (k == 47);
    end
    start_run(1'b1);
    dones = 0;
    for (int k = 0; k <= 70; k++) begin
      if (k > 0) @(negedge clk);
      if (done_o) dones++;
      if (k % 16 == 0) chk($sformatf("cont_c%0d_sel", k), 32'(OscSel_o), 32'((k / 16) % 3));
      if (k == 47 || k == 48) chk($sformatf("cont_c%0d_sweep", k), 32'(SweepCnt_o), k == 48 ? 1 : 0);
    end
    chk("cont_no_done", 32'(dones), 0);
    chk("cont_busy", 32'(busy_o), 1);
    #2 rstn = 1'b0;
    #1 chk("async_reset_outs", outs(), 0);
    @(negedge clk);
    rstn = 1'b1;
    start_run(1'b0);
    for (int k = 1; k <= 21; k++) @(negedge clk);
    chk("stop_pre_sel", 32'(OscSel_o), 1);
    stop_i = 1'b1;
    @(negedge clk);
    stop_i = 1'b0;
    chk("stop_busy", 32'(busy_o), 0);
    chk("stop_resetn", 32'(Resetn_o), 0);
    chk("stop_done", 32'(done_o), 0);
    hits = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy_o || Resetn_o || Sample_o || done_o) hits++;
    end
    chk("stop_quiet", 32'(hits), 0);
    start_i = 1'b1;
    stop_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    stop_i = 1'b0;
    chk("start_with_stop_busy", 32'(busy_o), 0);
    @(negedge clk);
    chk("start_with_stop_resetn", 32'(Resetn_o), 0);
    start_run(1'b0);
    for (int k = 1; k <= 47; k++) begin
      @(negedge clk);
      if (k == 8) chk("restart_sample", 32'(Sample_o), 1);
    end
    stop_i = 1'b1;
    @(negedge clk);
    stop_i = 1'b0;
    chk("stop_at_end_done", 32'(done_o), 0);
    chk("stop_at_end_sweep", 32'(SweepCnt_o), 0);
    chk("stop_at_end_busy", 32'(busy_o), 0);
`ifdef OSC_MASK_EN
    osc_mask_i = 3'b101;
    start_run(1'b0);
    for (int k = 0; k <= 32; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 0) chk("mask_c0_sel", 32'(OscSel_o), 0);
      if (k == 16) chk("mask_c16_sel", 32'(OscSel_o), 2);
      if (k == 31) chk("mask_c31_done", 32'(done_o), 0);
      if (k == 32) chk("mask_c32_done", 32'(done_o), 1);
    end
    osc_mask_i = 3'b000;
    start_run(1'b0);
    chk("mask0_busy", 32'(busy_o), 1);
    @(negedge clk);
    chk("mask0_done", 32'(done_o), 1);
    chk("mask0_idle", 32'(busy_o), 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
